icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache; successor to the direct-mapped, externally-filled I-cache.
- Sits between the Instruction Unit and the memory controller.
- Serves hits combinationally in the lookup cycle.
- On a miss, owns its own refill FSM: issues a block request to memory, installs the returned line into a victim way, and supports a full flush.

Parameters:
- BLOCK_WIDTH, 4, log2 bytes per line; must be >= 2.
- BLOCK_SIZE, 2**BLOCK_WIDTH, bytes per line.
- SET_WIDTH, 4, log2 number of sets.
- WAYS, 2, associativity; power of two, 1..8.
- WAY_WIDTH, max(1, log2(WAYS)), victim/round-robin pointer width.

Ports:
- clkIn, input, 1, system clock.
- resetIn, input, 1, synchronous active-high reset.
- flushIn, input, 1, invalidate all lines.
- instrReqIn, input, 1, lookup request valid.
- instrAddrIn, input, 32, fetch address, word aligned.
- instrOutValid, output, 1, hit: instrOut is valid this cycle.
- instrOut, output, 32, fetched instruction word.
- busy, output, 1, refill in progress.
- memReqOut, output, 1, block read request.
- memAddrOut, output, [31:BLOCK_WIDTH], requested block address.
- memDataValid, input, 1, memory returns block (single-cycle pulse).
- memDataIn, input, BLOCK_SIZE*8, block data, word 0 in bits [31:0].

Behaviour:
- Clock and reset: single clock clkIn. resetIn is synchronous and active-high.
- Reset clears all valid bits, all round-robin pointers and the drop flag, and puts the FSM in IDLE.
- Outputs after reset: instrOutValid=0, instrOut=0, memReqOut=0, busy=0, memAddrOut=0.
- Address split:
  - tag = instrAddrIn[31:BLOCK_WIDTH+SET_WIDTH]
  - set = instrAddrIn[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH]
  - word = instrAddrIn[BLOCK_WIDTH-1:2]
- Lookup (combinational, any state):
  - hit = instrReqIn AND some way in the set is valid with a matching tag.
  - instrOutValid = hit. instrOut = the selected word of the hitting way, else 0.
  - At most one way can match: the fill path never installs a duplicate.
- FSM state IDLE:
  - instrReqIn && !hit && !flushIn: latch the block address into memAddrOut, go to REQ.
  - A miss while flushIn is high does not start a refill.
- FSM state REQ:
  - memReqOut=1 and busy=1. memAddrOut is held stable.
  - Hits are still served (hit-under-miss). Further misses are ignored; the requester retries.
  - On memDataValid: write the victim way's tag, data (words 0..BLOCK_SIZE/4-1) and valid bit; advance the set's round-robin pointer (mod WAYS); go to IDLE.
  - memReqOut falls on the next cycle. The installed line hits from the cycle after memDataValid.
- Victim selection: the lowest-index invalid way in the set; otherwise the set's round-robin pointer.
  - The pointer advances on every fill of that set, whichever way the fill used.
- Miss-to-hit latency: miss at cycle t, memReqOut high from t+1, memDataValid at t+1+L, hit at t+2+L.
- memDataValid outside REQ is ignored; no state change.
- Flush:
  - flushIn clears all valid bits at the next edge. Round-robin pointers are unchanged.
  - flushIn during REQ sets a drop flag. The returning block is not installed and its pointer does not advance; the FSM still returns to IDLE.
  - flushIn in the same cycle as memDataValid: the flush wins and the line is not installed.
  - The drop flag clears on return to IDLE.
- Reset during REQ: memReqOut drops on the next cycle. A later memDataValid is ignored.
- WAYS=1 degenerates to direct-mapped. The pointer is a constant 0.

Decomposition:
- Shared package icache_pkg:
  - FSM state encoding (IDLE, REQ).
  - Localparams TAG_WIDTH = 32-BLOCK_WIDTH-SET_WIDTH and WORDS = BLOCK_SIZE/4.
- Sub-module icache_way, instantiated WAYS times. It holds one way's valid/tag/data arrays and provides:
  - combinational set-indexed read with tag compare;
  - a write-enable fill port;
  - a flush port.
- Top level holds the FSM, the round-robin pointers, the victim mux and the hit mux.

Test Plan:
- Reset, then lookup 0x0000_0100 -> instrOutValid=0; memReqOut=1 with memAddrOut=0x0000_010 next cycle.
  - Return memDataIn words {0x13,0x93,0x113,0x193} -> lookup 0x104 hits with 0x93 the cycle after memDataValid.
- Fill 0x0000_0100 and 0x0000_1100 (same set, WAYS=2) -> both hit.
  - Miss at 0x0000_2100 evicts the round-robin way (way 0, since the set's pointer has advanced twice); 0x1100 still hits and 0x100 misses.
- During REQ for 0x200, lookup a resident 0x104 -> hit served; memAddrOut stays 0x0000_020.
- flushIn pulse with no refill in flight -> the next cycle all previously resident lines miss; pointers are unchanged.
- flushIn asserted in REQ, or in the same cycle as memDataValid -> returned line not installed; lookup of that block misses and starts a new request.
- resetIn mid-REQ, then memDataValid 2 cycles later -> no install; memReqOut=0 and busy=0 throughout.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM state
// encoding and geometry constants for the default configuration.
package icache_pkg;

  localparam int DEF_BLOCK_WIDTH = 4;
  localparam int DEF_SET_WIDTH   = 4;
  localparam int TAG_WIDTH       = 32 - DEF_BLOCK_WIDTH - DEF_SET_WIDTH;
  localparam int WORDS           = (2 ** DEF_BLOCK_WIDTH) / 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  function automatic int tagWidthOf(input int blockWidth, input int setWidth);
    return 32 - blockWidth - setWidth;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid/tag/line storage with a
// combinational lookup port, a fill port and a whole-way flush.
module icache_way
  import icache_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int SET_WIDTH   = DEF_SET_WIDTH,
  localparam int TagW  = tagWidthOf(BLOCK_WIDTH, SET_WIDTH),
  localparam int LineW = (2 ** BLOCK_WIDTH) * 8
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic                 flushIn,
  input  logic [SET_WIDTH-1:0] rdSet,
  input  logic [TagW-1:0]      rdTag,
  output logic                 rdHit,
  output logic [LineW-1:0]     rdLine,
  input  logic [SET_WIDTH-1:0] wrSet,
  output logic                 wrSetValid,
  input  logic                 wrEn,
  input  logic [TagW-1:0]      wrTag,
  input  logic [LineW-1:0]     wrLine
);

  localparam int Sets = 2 ** SET_WIDTH;

  logic [Sets-1:0]  valid;
  logic [TagW-1:0]  tagMem  [Sets];
  logic [LineW-1:0] dataMem [Sets];

  assign rdHit      = valid[rdSet] && (tagMem[rdSet] == rdTag);
  assign rdLine     = dataMem[rdSet];
  assign wrSetValid = valid[wrSet];

  // Flush beats a same-cycle fill so a dropped refill never becomes valid.
  always_ff @(posedge clkIn) begin
    if (resetIn || flushIn) begin
      valid <= '0;
    end else if (wrEn) begin
      valid[wrSet] <= 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (wrEn) begin
      tagMem[wrSet]  <= wrTag;
      dataMem[wrSet] <= wrLine;
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with its own refill FSM, round-robin
// replacement per set, hit-under-miss and a flush that can cancel a refill.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH,
  parameter int SET_WIDTH   = DEF_SET_WIDTH,
  parameter int WAYS        = 2,
  parameter int WAY_WIDTH   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    flushIn,
  input  logic                    instrReqIn,
  input  logic [31:0]             instrAddrIn,
  output logic                    instrOutValid,
  output logic [31:0]             instrOut,
  output logic                    busy,
  output logic                    memReqOut,
  output logic [31:BLOCK_WIDTH]   memAddrOut,
  input  logic                    memDataValid,
  input  logic [BLOCK_SIZE*8-1:0] memDataIn
);

  localparam int TagW  = tagWidthOf(BLOCK_WIDTH, SET_WIDTH);
  localparam int LineW = BLOCK_SIZE * 8;
  localparam int Sets  = 2 ** SET_WIDTH;

  logic [0:0]           state;
  logic                 dropFlag;
  logic [WAY_WIDTH-1:0] rrPtr [Sets];

  logic [TagW-1:0]        lookupTag;
  logic [SET_WIDTH-1:0]   lookupSet;
  logic [BLOCK_WIDTH-1:0] lookupOffset;
  logic [TagW-1:0]        fillTag;
  logic [SET_WIDTH-1:0]   fillSet;

  logic [WAYS-1:0]      wayHit;
  logic [LineW-1:0]     wayLine [WAYS];
  logic [WAYS-1:0]      fillValid;
  logic [WAYS-1:0]      wayWrEn;
  logic [LineW-1:0]     lineSel;
  logic [WAY_WIDTH-1:0] victim;
  logic [WAY_WIDTH-1:0] nextPtr;
  logic                 victimFound;
  logic                 hit;
  logic                 install;
  int                   wordIdx;

  assign lookupTag    = instrAddrIn[31:BLOCK_WIDTH+SET_WIDTH];
  assign lookupSet    = instrAddrIn[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
  assign lookupOffset = instrAddrIn[BLOCK_WIDTH-1:0];
  assign fillTag      = memAddrOut[31:BLOCK_WIDTH+SET_WIDTH];
  assign fillSet      = memAddrOut[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    icache_way #(
      .BLOCK_WIDTH(BLOCK_WIDTH),
      .SET_WIDTH  (SET_WIDTH)
    ) uWay (
      .clkIn     (clkIn),
      .resetIn   (resetIn),
      .flushIn   (flushIn),
      .rdSet     (lookupSet),
      .rdTag     (lookupTag),
      .rdHit     (wayHit[w]),
      .rdLine    (wayLine[w]),
      .wrSet     (fillSet),
      .wrSetValid(fillValid[w]),
      .wrEn      (wayWrEn[w]),
      .wrTag     (fillTag),
      .wrLine    (memDataIn)
    );
  end

  // At most one way matches, so OR-ing the gated lines selects the hit.
  always_comb begin
    lineSel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (wayHit[w]) lineSel = lineSel | wayLine[w];
    end
  end

  assign hit           = instrReqIn && (|wayHit);
  assign wordIdx       = int'(lookupOffset) / 4;
  assign instrOutValid = hit;
  assign instrOut      = hit ? lineSel[wordIdx*32 +: 32] : 32'h0;

  always_comb begin
    victim      = rrPtr[fillSet];
    victimFound = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victimFound && !fillValid[w]) begin
        victim      = WAY_WIDTH'(w);
        victimFound = 1'b1;
      end
    end
  end

  assign install = (state == ST_REQ) && memDataValid && !dropFlag && !flushIn;
  assign nextPtr = (rrPtr[fillSet] == WAY_WIDTH'(WAYS - 1)) ? '0
                                                            : rrPtr[fillSet] + WAY_WIDTH'(1);

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      wayWrEn[w] = install && (victim == WAY_WIDTH'(w));
    end
  end

  assign memReqOut = (state == ST_REQ);
  assign busy      = (state == ST_REQ);

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state      <= ST_IDLE;
      dropFlag   <= 1'b0;
      memAddrOut <= '0;
      for (int s = 0; s < Sets; s++) rrPtr[s] <= '0;
    end else if (state == ST_IDLE) begin
      if (instrReqIn && !hit && !flushIn) begin
        memAddrOut <= instrAddrIn[31:BLOCK_WIDTH];
        state      <= ST_REQ;
      end
    end else begin
      if (memDataValid) begin
        state    <= ST_IDLE;
        dropFlag <= 1'b0;
        if (install) rrPtr[fillSet] <= nextPtr;
      end else if (flushIn) begin
        dropFlag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed and randomized bench for icache_assoc, compared cycle by cycle
// against a behavioural cache model kept in plain arrays.
module tb_icache_assoc;

  localparam int BW   = 4;
  localparam int SW   = 4;
  localparam int WAYS = 2;
  localparam int SETS = 2 ** SW;

  logic         clkIn = 1'b0;
  logic         resetIn = 1'b1;
  logic         flushIn = 1'b0;
  logic         instrReqIn = 1'b0;
  logic [31:0]  instrAddrIn = '0;
  logic         instrOutValid;
  logic [31:0]  instrOut;
  logic         busy;
  logic         memReqOut;
  logic [31:BW] memAddrOut;
  logic         memDataValid = 1'b0;
  logic [127:0] memDataIn = '0;

  int checks = 0;
  int errors = 0;

  bit           mValid [SETS][WAYS];
  logic [23:0]  mTag   [SETS][WAYS];
  logic [127:0] mLine  [SETS][WAYS];
  int           mRr    [SETS];
  bit           mPending = 1'b0;
  bit           mDrop = 1'b0;
  logic [27:0]  mAddr = '0;

  logic [31:0] obsValid, obsData, obsReq, obsBusy, obsAddr;

  icache_assoc #(
    .BLOCK_WIDTH(BW),
    .SET_WIDTH  (SW),
    .WAYS       (WAYS)
  ) dut (
    .clkIn        (clkIn),
    .resetIn      (resetIn),
    .flushIn      (flushIn),
    .instrReqIn   (instrReqIn),
    .instrAddrIn  (instrAddrIn),
    .instrOutValid(instrOutValid),
    .instrOut     (instrOut),
    .busy         (busy),
    .memReqOut    (memReqOut),
    .memAddrOut   (memAddrOut),
    .memDataValid (memDataValid),
    .memDataIn    (memDataIn)
  );

  always #5 clkIn = ~clkIn;

  function automatic int modelHitWay(input logic req, input logic [31:0] addr);
    int s;
    s = int'(addr[7:4]);
    if (!req) return -1;
    for (int w = 0; w < WAYS; w++) begin
      if (mValid[s][w] && mTag[s][w] == addr[31:8]) return w;
    end
    return -1;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares this cycle's outputs with what the model predicts for them.
  task automatic checkOutput();
    int hw;
    int s;
    logic [31:0] expData;
    hw = modelHitWay(instrReqIn, instrAddrIn);
    s = int'(instrAddrIn[7:4]);
    expData = (hw >= 0) ? mLine[s][hw][int'(instrAddrIn[3:2])*32 +: 32] : 32'h0;
    obsValid = {31'b0, instrOutValid};
    obsData  = instrOut;
    obsReq   = {31'b0, memReqOut};
    obsBusy  = {31'b0, busy};
    obsAddr  = {4'b0, memAddrOut};
    checkVal("instrOutValid", obsValid, {31'b0, hw >= 0});
    checkVal("instrOut", obsData, expData);
    checkVal("memReqOut", obsReq, {31'b0, mPending});
    checkVal("busy", obsBusy, {31'b0, mPending});
    checkVal("memAddrOut", obsAddr, {4'b0, mAddr});
  endtask

  task automatic modelInstall(input logic [127:0] line);
    int s;
    int v;
    s = int'(mAddr[3:0]);
    v = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (v < 0 && !mValid[s][w]) v = w;
    end
    if (v < 0) v = mRr[s];
    mValid[s][v] = 1'b1;
    mTag[s][v]   = mAddr[27:4];
    mLine[s][v]  = line;
    mRr[s]       = (mRr[s] + 1) % WAYS;
  endtask

  task automatic modelUpdate();
    bit lkHit;
    if (resetIn) begin
      for (int s = 0; s < SETS; s++) begin
        mRr[s] = 0;
        for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
      end
      mPending = 1'b0;
      mDrop    = 1'b0;
      mAddr    = '0;
      return;
    end
    lkHit = modelHitWay(instrReqIn, instrAddrIn) >= 0;
    if (mPending) begin
      if (memDataValid) begin
        if (!mDrop && !flushIn) modelInstall(memDataIn);
        mPending = 1'b0;
        mDrop    = 1'b0;
      end else if (flushIn) begin
        mDrop = 1'b1;
      end
    end else if (instrReqIn && !lkHit && !flushIn) begin
      mPending = 1'b1;
      mAddr    = instrAddrIn[31:4];
    end
    if (flushIn) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, cross the edge.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic flush,
                               input logic mdv, input logic rst, input logic [127:0] line);
    instrReqIn   = req;
    instrAddrIn  = addr;
    flushIn      = flush;
    memDataValid = mdv;
    resetIn      = rst;
    memDataIn    = line;
    @(negedge clkIn);
    checkOutput();
    modelUpdate();
    @(posedge clkIn);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic lookup(input logic [31:0] addr);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic returnLine(input logic [127:0] line);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, line);
  endtask

  initial begin
    logic [127:0] lineA;
    logic [127:0] line1100;
    logic [127:0] line2100;
    logic [127:0] line200;
    logic [31:0]  rAddr;
    logic         rReq, rFlush, rRst, rMdv;

    lineA    = {32'h193, 32'h113, 32'h93, 32'h13};
    line1100 = {32'hA003, 32'hA002, 32'hA001, 32'hA000};
    line2100 = {32'hB003, 32'hB002, 32'hB001, 32'hB000};
    line200  = {32'hC003, 32'hC002, 32'hC001, 32'hC000};
    for (int s = 0; s < SETS; s++) begin
      mRr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mValid[s][w] = 1'b0;
        mTag[s][w]   = '0;
        mLine[s][w]  = '0;
      end
    end

    @(posedge clkIn);
    #1;
    $display("[TB] reset and first refill");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0);
    idle(1);
    checkVal("rstValid", obsValid, 32'h0);
    checkVal("rstData", obsData, 32'h0);
    checkVal("rstReq", obsReq, 32'h0);
    checkVal("rstBusy", obsBusy, 32'h0);
    checkVal("rstAddr", obsAddr, 32'h0);
    lookup(32'h100);
    checkVal("firstMissValid", obsValid, 32'h0);
    idle(1);
    checkVal("firstReq", obsReq, 32'h1);
    checkVal("firstReqAddr", obsAddr, 32'h10);
    idle(2);
    returnLine(lineA);
    lookup(32'h104);
    checkVal("fillHitValid", obsValid, 32'h1);
    checkVal("fillHitData", obsData, 32'h93);

    $display("[TB] second way and round-robin eviction");
    lookup(32'h1100);
    idle(1);
    returnLine(line1100);
    lookup(32'h100);
    checkVal("way0Hit", obsData, 32'h13);
    lookup(32'h1108);
    checkVal("way1Hit", obsData, 32'hA002);
    lookup(32'h2100);
    idle(1);
    returnLine(line2100);
    lookup(32'h1104);
    checkVal("survivorHit", obsData, 32'hA001);
    lookup(32'h100);
    checkVal("evictedMiss", obsValid, 32'h0);
    idle(1);
    returnLine(lineA);
    lookup(32'h104);
    checkVal("refillHit", obsData, 32'h93);

    $display("[TB] hit under miss");
    lookup(32'h200);
    lookup(32'h104);
    checkVal("humValid", obsValid, 32'h1);
    checkVal("humData", obsData, 32'h93);
    checkVal("humAddr", obsAddr, 32'h20);
    returnLine(line200);

    $display("[TB] flush behaviour");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    lookup(32'h104);
    checkVal("flushMiss", obsValid, 32'h0);
    idle(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    returnLine(lineA);
    lookup(32'h104);
    checkVal("dropMiss", obsValid, 32'h0);
    idle(1);
    checkVal("dropReq", obsReq, 32'h1);
    checkVal("dropReqAddr", obsAddr, 32'h10);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, lineA);
    lookup(32'h104);
    checkVal("sameCycleFlushMiss", obsValid, 32'h0);
    idle(1);
    checkVal("sameCycleReq", obsReq, 32'h1);

    $display("[TB] reset during refill");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0);
    idle(1);
    checkVal("rstReqReq", obsReq, 32'h0);
    checkVal("rstReqBusy", obsBusy, 32'h0);
    returnLine(lineA);
    checkVal("strayReq", obsReq, 32'h0);
    checkVal("strayBusy", obsBusy, 32'h0);
    lookup(32'h104);
    checkVal("strayMiss", obsValid, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      rAddr  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
             | (32'($urandom_range(0, 3)) << 2);
      rReq   = $urandom_range(0, 99) < 70;
      rFlush = $urandom_range(0, 99) < 2;
      rRst   = $urandom_range(0, 999) < 4;
      rMdv   = mPending ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      applyStimulus(rReq, rAddr, rFlush, rMdv, rRst, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
